// File: rtl/timeout_arbiter.sv
// timeout_arbiter
//   Two requesters share one seconds timebase. The winner of a round-robin
//   arbitration owns the timebase and gets a countdown of dur seconds; when it
//   reaches zero the owner receives a one-cycle done pulse. An owner can abort
//   its countdown with cancel or by dropping its request.
//
// Ports
//   clock_i      system clock, rising edge active
//   reset_i      asynchronous active-high reset
//   req_i[1:0]   level request per requester
//   dur0_i[2:0]  requester 0 timeout in seconds, sampled on the grant edge
//   dur1_i[2:0]  requester 1 timeout in seconds, sampled on the grant edge
//   cancel_i     aborts the running countdown
//   gnt_o[1:0]   one-hot owner while counting, 0 otherwise
//   done_o[1:0]  one-cycle expiry pulse to the owner
//   busy_o       high whenever the FSM is not IDLE
//   remaining_o  whole seconds left for the current owner
module timeout_arbiter #(
    parameter int TICK_CYCLES   = 5000000,
    parameter int TICKS_PER_SEC = 10
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic [1:0] req_i,
    input  logic [2:0] dur0_i,
    input  logic [2:0] dur1_i,
    input  logic       cancel_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic [2:0] remaining_o
);

    localparam logic [25:0] TICK_LAST = 26'(TICK_CYCLES - 1);
    localparam logic [3:0]  SEC_LAST  = 4'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;   // index of the current/last owner
    logic        last_q,  last_d;    // last-served pointer for round-robin
    logic [2:0]  rem_q,   rem_d;
    logic [25:0] presc_q, presc_d;
    logic [3:0]  sub_q,   sub_d;

    logic tick, sec;
    logic last_eff, winner, abort;

    assign tick = (presc_q == TICK_LAST);
    assign sec  = tick && (sub_q == SEC_LAST);

    // In DONE the pointer update to the finishing owner has not landed in
    // last_q yet, so arbitration there must already see the owner as served.
    assign last_eff = (state_q == DONE) ? owner_q : last_q;
    assign winner   = (req_i == 2'b11) ? ~last_eff : req_i[1];
    assign abort    = cancel_i || !req_i[owner_q];

    // State register
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rem_q   <= 3'd0;
            presc_q <= 26'd0;
            sub_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rem_q   <= rem_d;
            presc_q <= presc_d;
            sub_q   <= sub_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    state_d = RUN;
                    owner_d = winner;
                    rem_d   = winner ? dur1_i : dur0_i;
                end
            end
            RUN: begin
                // Abort wins over both expiry paths.
                if (abort) begin
                    state_d = IDLE;
                    rem_d   = 3'd0;
                    last_d  = owner_q;
                end else if (rem_q == 3'd0) begin
                    state_d = DONE;
                end else if (sec) begin
                    rem_d = rem_q - 3'd1;
                    if (rem_q == 3'd1) state_d = DONE;
                end
            end
            DONE: begin
                // The edge leaving DONE is already a grant opportunity, so
                // gnt is low for exactly the DONE cycle between owners.
                last_d = owner_q;
                if (req_i != 2'b00) begin
                    state_d = RUN;
                    owner_d = winner;
                    rem_d   = winner ? dur1_i : dur0_i;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = 3'd0;
            end
        endcase
    end

    // Timebase only advances across RUN->RUN; every grant starts it from
    // zero so the first second is full length.
    always_comb begin
        presc_d = 26'd0;
        sub_d   = 4'd0;
        if (state_q == RUN && state_d == RUN) begin
            presc_d = tick ? 26'd0 : presc_q + 26'd1;
            sub_d   = sub_q;
            if (tick) sub_d = (sub_q == SEC_LAST) ? 4'd0 : sub_q + 4'd1;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        gnt_o       = 2'b00;
        done_o      = 2'b00;
        busy_o      = (state_q != IDLE);
        remaining_o = rem_q;
        if (state_q == RUN)  gnt_o  = {owner_q, ~owner_q};
        if (state_q == DONE) done_o = {owner_q, ~owner_q};
    end

endmodule
